// File: rtl/ysyx_22050612_mem_arbiter.sv
// Two-requester arbiter sharing one memory port between IFU fetches and LSU loads/stores.
// One transaction in flight; LSU priority with an IFU starvation guard and a WAIT timeout.
module ysyx_22050612_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [63:0] ifu_req_addr,
  output logic        ifu_resp_valid,
  output logic [63:0] ifu_resp_data,
  output logic        ifu_resp_err,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [63:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [63:0] lsu_req_wdata,
  input  logic [7:0]  lsu_req_wmask,
  output logic        lsu_resp_valid,
  output logic [63:0] lsu_resp_data,
  output logic        lsu_resp_err,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,

  output logic        busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e        state_q;
  logic          owner_lsu_q;
  logic [63:0]   addr_q;
  logic          wen_q;
  logic [63:0]   wdata_q;
  logic [7:0]    wmask_q;
  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic [TW-1:0] tcnt_q;
  logic          mem_req_valid_q;
  logic          ifu_resp_valid_q;
  logic [63:0]   ifu_resp_data_q;
  logic          ifu_resp_err_q;
  logic          lsu_resp_valid_q;
  logic [63:0]   lsu_resp_data_q;
  logic          lsu_resp_err_q;

  logic          grant_lsu;
  logic          grant_ifu;
  logic          resp_fire;
  logic          resp_err_d;
  logic [63:0]   resp_data_d;

  // Grants are gated by rst_n so ready stays low while reset is held.
  always_comb begin
    grant_lsu = 1'b0;
    grant_ifu = 1'b0;
    if (rst_n && state_q == IDLE) begin
      grant_lsu = lsu_req_valid && !(ifu_req_valid && streak_q == STREAK_MAX);
      grant_ifu = ifu_req_valid && !grant_lsu;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (grant_ifu) begin
      streak_d = '0;
    end else if (grant_lsu) begin
      if (!ifu_req_valid) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  // A response in the final WAIT cycle beats the timeout; writes return zero data.
  always_comb begin
    resp_fire   = (state_q == WAIT) && (mem_resp_valid || tcnt_q == TCNT_LAST);
    resp_err_d  = !mem_resp_valid;
    resp_data_d = (mem_resp_valid && !wen_q) ? mem_resp_data : 64'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      owner_lsu_q      <= 1'b0;
      addr_q           <= '0;
      wen_q            <= 1'b0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      streak_q         <= '0;
      tcnt_q           <= '0;
      mem_req_valid_q  <= 1'b0;
      ifu_resp_valid_q <= 1'b0;
      ifu_resp_data_q  <= '0;
      ifu_resp_err_q   <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      lsu_resp_data_q  <= '0;
      lsu_resp_err_q   <= 1'b0;
    end else begin
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      streak_q         <= streak_d;
      case (state_q)
        IDLE: begin
          if (grant_lsu) begin
            owner_lsu_q     <= 1'b1;
            addr_q          <= lsu_req_addr;
            wen_q           <= lsu_req_wen;
            wdata_q         <= lsu_req_wdata;
            wmask_q         <= lsu_req_wmask;
            mem_req_valid_q <= 1'b1;
            state_q         <= ISSUE;
          end else if (grant_ifu) begin
            owner_lsu_q     <= 1'b0;
            addr_q          <= ifu_req_addr;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            mem_req_valid_q <= 1'b1;
            state_q         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            tcnt_q          <= '0;
            state_q         <= WAIT;
          end
        end
        WAIT: begin
          if (resp_fire) begin
            if (owner_lsu_q) begin
              lsu_resp_valid_q <= 1'b1;
              lsu_resp_data_q  <= resp_data_d;
              lsu_resp_err_q   <= resp_err_d;
            end else begin
              ifu_resp_valid_q <= 1'b1;
              ifu_resp_data_q  <= resp_data_d;
              ifu_resp_err_q   <= resp_err_d;
            end
            state_q <= RESP;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ifu_req_ready  = grant_ifu;
  assign lsu_req_ready  = grant_lsu;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_resp_data  = ifu_resp_data_q;
  assign ifu_resp_err   = ifu_resp_err_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_resp_data  = lsu_resp_data_q;
  assign lsu_resp_err   = lsu_resp_err_q;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Bench for the memory arbiter: a transaction-timing model predicts every output each cycle
// from the grant rule and the memory delays chosen by the bench.
module tb_ysyx_22050612_mem_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 8;
  localparam int NEVER        = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req_valid = 1'b0, ifu_req_ready;
  logic [63:0] ifu_req_addr = '0;
  logic        ifu_resp_valid, ifu_resp_err;
  logic [63:0] ifu_resp_data;
  logic        lsu_req_valid = 1'b0, lsu_req_ready;
  logic [63:0] lsu_req_addr = '0, lsu_req_wdata = '0;
  logic        lsu_req_wen = 1'b0;
  logic [7:0]  lsu_req_wmask = '0;
  logic        lsu_resp_valid, lsu_resp_err;
  logic [63:0] lsu_resp_data;
  logic        mem_req_valid, mem_req_wen;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_data = '0;
  logic        busy;

  ysyx_22050612_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit          ifuPend = 0, lsuPend = 0;
  logic [63:0] ifuAddr, lsuAddr, lsuWdata;
  logic        lsuWen;
  logic [7:0]  lsuWmask;

  bit          act = 0, actLsu = 0;
  logic [63:0] aAddr, aWdata, memData;
  logic        aWen;
  logic [7:0]  aWmask;
  int          tAcc, dly, rsp;
  int          streak = 0;
  logic [63:0] expIfuData = '0, expLsuData = '0;
  logic        expIfuErr = 0, expLsuErr = 0;

  bit          randReq = 0, refill = 0, noise = 0, planDataEn = 0;
  int          reqPct = 40, planD = -1, planR = -1;
  logic [63:0] planData;

  int          ifuAccCyc, lsuAccCyc, ifuRespCyc, lsuRespCyc, memValidCnt;
  logic [63:0] ifuRespData, lsuRespData;
  logic        ifuRespErr, lsuRespErr;
  string       grantLog = "";

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
    end
  endtask

  function automatic int respCyc();
    return tAcc + 2 + dly + ((rsp < TIMEOUT) ? rsp : TIMEOUT - 1) + 1;
  endfunction

  function automatic bit inIssue(int c);
    return act && c >= tAcc + 1 && c <= tAcc + 1 + dly;
  endfunction

  function automatic bit inWait(int c);
    return act && c >= tAcc + 2 + dly && c < respCyc();
  endfunction

  task automatic modelReset();
    act = 0; ifuPend = 0; lsuPend = 0; streak = 0;
    expIfuData = '0; expLsuData = '0; expIfuErr = 0; expLsuErr = 0;
  endtask

  task automatic applyStimulus();
    if ((randReq && $urandom_range(99) < reqPct) || refill) begin
      if (!ifuPend) begin
        ifuPend = 1; ifuAddr = {$urandom, $urandom};
      end
    end
    if ((randReq && $urandom_range(99) < reqPct) || refill) begin
      if (!lsuPend) begin
        lsuPend = 1; lsuAddr = {$urandom, $urandom}; lsuWen = 1'($urandom_range(1));
        lsuWdata = {$urandom, $urandom}; lsuWmask = 8'($urandom);
      end
    end
    ifu_req_valid = ifuPend;
    ifu_req_addr  = ifuPend ? ifuAddr : {$urandom, $urandom};
    lsu_req_valid = lsuPend;
    lsu_req_addr  = lsuPend ? lsuAddr : {$urandom, $urandom};
    lsu_req_wen   = lsuPend ? lsuWen : 1'($urandom_range(1));
    lsu_req_wdata = lsuPend ? lsuWdata : {$urandom, $urandom};
    lsu_req_wmask = lsuPend ? lsuWmask : 8'($urandom);
    mem_resp_data = {$urandom, $urandom};
    mem_resp_valid = 0;
    if (inIssue(cyc)) mem_req_ready = (cyc == tAcc + 1 + dly);
    else mem_req_ready = noise ? 1'($urandom_range(1)) : 1'b0;
    if (inWait(cyc)) begin
      if (rsp < TIMEOUT && cyc == tAcc + 2 + dly + rsp) begin
        mem_resp_valid = 1; mem_resp_data = memData;
      end
    end else if (noise) begin
      mem_resp_valid = ($urandom_range(3) == 0);
    end
  endtask

  task automatic planTxn();
    int pick;
    tAcc = cyc;
    dly = (planD >= 0) ? planD : int'($urandom_range(3));
    pick = int'($urandom_range(9));
    if (planR >= 0) rsp = planR;
    else if (pick == 0) rsp = NEVER;
    else if (pick == 1) rsp = TIMEOUT - 1;
    else rsp = int'($urandom_range(3));
    memData = planDataEn ? planData : {$urandom, $urandom};
    act = 1;
  endtask

  task automatic checkOutput();
    bit lsuWins, ifuWins, issuing, respNow;
    lsuWins = 0; ifuWins = 0;
    if (!act && rst_n) begin
      lsuWins = lsu_req_valid && !(ifu_req_valid && streak == STARVE_LIMIT);
      ifuWins = ifu_req_valid && !lsuWins;
    end
    issuing = inIssue(cyc);
    respNow = act && cyc == respCyc();
    if (respNow) begin
      if (actLsu) begin
        expLsuData = (rsp < TIMEOUT && !aWen) ? memData : 64'd0;
        expLsuErr  = (rsp >= TIMEOUT);
      end else begin
        expIfuData = (rsp < TIMEOUT) ? memData : 64'd0;
        expIfuErr  = (rsp >= TIMEOUT);
      end
    end
    chk("busy", busy, act);
    chk("ifu_req_ready", ifu_req_ready, ifuWins);
    chk("lsu_req_ready", lsu_req_ready, lsuWins);
    chk("mem_req_valid", mem_req_valid, issuing);
    if (issuing) begin
      chk("mem_req_addr", mem_req_addr, aAddr);
      chk("mem_req_wen", mem_req_wen, aWen);
      chk("mem_req_wmask", mem_req_wmask, aWmask);
      if (actLsu) chk("mem_req_wdata", mem_req_wdata, aWdata);
    end
    chk("ifu_resp_valid", ifu_resp_valid, respNow && !actLsu);
    chk("lsu_resp_valid", lsu_resp_valid, respNow && actLsu);
    chk("ifu_resp_data", ifu_resp_data, expIfuData);
    chk("ifu_resp_err", ifu_resp_err, expIfuErr);
    chk("lsu_resp_data", lsu_resp_data, expLsuData);
    chk("lsu_resp_err", lsu_resp_err, expLsuErr);

    if (mem_req_valid) memValidCnt++;
    if (ifu_resp_valid) begin
      ifuRespCyc = cyc; ifuRespData = ifu_resp_data; ifuRespErr = ifu_resp_err;
    end
    if (lsu_resp_valid) begin
      lsuRespCyc = cyc; lsuRespData = lsu_resp_data; lsuRespErr = lsu_resp_err;
    end

    if (respNow) begin
      act = 0;
    end else if (lsuWins) begin
      streak = ifu_req_valid ? ((streak < STARVE_LIMIT) ? streak + 1 : streak) : 0;
      actLsu = 1; aAddr = lsuAddr; aWen = lsuWen; aWdata = lsuWdata; aWmask = lsuWmask;
      lsuPend = 0; lsuAccCyc = cyc; grantLog = {grantLog, "L"};
      planTxn();
    end else if (ifuWins) begin
      streak = 0;
      actLsu = 0; aAddr = ifuAddr; aWen = 0; aWdata = '0; aWmask = '0;
      ifuPend = 0; ifuAccCyc = cyc; grantLog = {grantLog, "I"};
      planTxn();
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    applyStimulus();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (act || ifuPend || lsuPend); i++) step();
    chk("drain_idle", act || ifuPend || lsuPend, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state with reset held.
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // IFU read with immediate ready and one-cycle response.
    planD = 0; planR = 0; planDataEn = 1; planData = 64'h0010007300000413;
    ifuPend = 1; ifuAddr = 64'h8000_0000; ifuRespCyc = -1;
    for (int i = 0; i < 30 && ifuRespCyc < 0; i++) step();
    chk("t1_resp_seen", ifuRespCyc >= 0, 1);
    chk("t1_latency", 64'(ifuRespCyc - ifuAccCyc), 3);
    chk("t1_data", ifuRespData, 64'h0010007300000413);
    chk("t1_err", ifuRespErr, 0);
    planDataEn = 0;
    repeat (2) step();

    // Simultaneous requests: LSU first, IFU right after LSU RESP.
    grantLog = ""; ifuRespCyc = -1; lsuRespCyc = -1;
    ifuPend = 1; ifuAddr = 64'h8000_0040;
    lsuPend = 1; lsuAddr = 64'h8000_0100; lsuWen = 0; lsuWdata = '0; lsuWmask = '0;
    for (int i = 0; i < 40 && ifuRespCyc < 0; i++) step();
    chk("t2_order", grantLog == "LI", 1);
    chk("t2_ifu_after_lsu", 64'(ifuAccCyc - lsuRespCyc), 1);

    // Both requesters held valid: starvation guard order.
    planD = -1; planR = -1; refill = 1; grantLog = "";
    for (int i = 0; i < 400 && grantLog.len() < 10; i++) step();
    chk("t3_grant_order", grantLog == "LLLLILLLLI", 1);
    refill = 0;
    drain();

    // LSU write with mem_req_ready held off three cycles.
    planD = 3; planR = 1; memValidCnt = 0; lsuRespCyc = -1;
    lsuPend = 1; lsuAddr = 64'h8000_1000; lsuWen = 1;
    lsuWdata = 64'h1122334455667788; lsuWmask = 8'h0F;
    for (int i = 0; i < 30 && lsuRespCyc < 0; i++) step();
    chk("t4_req_cycles", memValidCnt, 4);
    chk("t4_data", lsuRespData, 0);
    chk("t4_err", lsuRespErr, 0);

    // LSU read that memory never answers, then a normal IFU read.
    planD = 0; planR = NEVER; lsuRespCyc = -1;
    lsuPend = 1; lsuAddr = 64'h8000_2000; lsuWen = 0;
    for (int i = 0; i < 40 && lsuRespCyc < 0; i++) step();
    chk("t5_timeout_latency", 64'(lsuRespCyc - lsuAccCyc), 10);
    chk("t5_err", lsuRespErr, 1);
    chk("t5_data", lsuRespData, 0);
    planR = 0; ifuRespCyc = -1; ifuPend = 1; ifuAddr = 64'h8000_0008;
    for (int i = 0; i < 30 && ifuRespCyc < 0; i++) step();
    chk("t5_ifu_err", ifuRespErr, 0);
    chk("t5_ifu_latency", 64'(ifuRespCyc - ifuAccCyc), 3);

    // Reset pulsed during WAIT abandons the transaction.
    planR = NEVER; lsuPend = 1; lsuAddr = 64'h8000_3000; lsuWen = 0; lsuAccCyc = -100;
    for (int i = 0; i < 20 && cyc != lsuAccCyc + 4; i++) step();
    chk("t6_in_wait", inWait(cyc), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_mem_req_valid", mem_req_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ifu_resp_valid", ifu_resp_valid, 0);
    chk("t6_lsu_resp_valid", lsu_resp_valid, 0);
    chk("t6_lsu_resp_data", lsu_resp_data, 0);
    modelReset();
    repeat (2) step();
    rst_n = 1'b1;
    lsuRespCyc = -1;
    repeat (15) step();
    chk("t6_no_stale_resp", lsuRespCyc, -1);
    planR = 0; ifuRespCyc = -1; ifuPend = 1; ifuAddr = 64'h8000_0010;
    for (int i = 0; i < 30 && ifuRespCyc < 0; i++) step();
    chk("t6_ifu_latency", 64'(ifuRespCyc - ifuAccCyc), 3);

    // Randomized traffic with random memory delays, timeouts and ignored noise.
    planD = -1; planR = -1; randReq = 1; noise = 1; reqPct = 40;
    repeat (2500) step();
    randReq = 0; noise = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
Name: ysyx_22050612_mem_arbiter

Overview:
Two-requester memory arbiter. It shares the single data-memory port between the IFU (instruction fetch, read-only) and the EXU/LSU load-store path (read/write with byte mask). The block sits between those units and the pmem access wrapper and keeps at most one transaction outstanding. Priority is fixed to the LSU, with an IFU starvation guard, and a response timeout returns an error instead of hanging the core.

Parameters:
STARVE_LIMIT, 4, consecutive LSU grants allowed while IFU is waiting before IFU is forced (>=1)
TIMEOUT, 255, maximum WAIT-state cycles before an error response (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_req_addr  in  64  IFU read address
ifu_resp_valid  out  1  one-cycle IFU response pulse
ifu_resp_data  out  64  IFU read data
ifu_resp_err  out  1  IFU response is a timeout error
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_req_addr  in  64  LSU address
lsu_req_wen  in  1  1 = write, 0 = read
lsu_req_wdata  in  64  write data
lsu_req_wmask  in  8  byte write mask
lsu_resp_valid  out  1  one-cycle LSU response pulse (issued for reads and writes)
lsu_resp_data  out  64  LSU read data (0 for writes)
lsu_resp_err  out  1  LSU response is a timeout error
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  64  latched address
mem_req_wen  out  1  latched write enable (0 for IFU)
mem_req_wdata  out  64  latched write data
mem_req_wmask  out  8  latched mask (0 for IFU)
mem_resp_valid  in  1  memory response
mem_resp_data  in  64  memory read data
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; all outputs = 0; latched request, owner, starvation and timeout counters = 0.
  - Reset asserted mid-transaction abandons it: mem_req_valid drops immediately, and no response is ever issued for the abandoned request.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is computed combinationally from the valids and the starvation counter.
  - Only the granted requester sees ready=1 (ready depends on valid; requesters must not make valid depend on ready).
  - On handshake: latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0) and the owner, then go to ISSUE.
  - No valid: stay in IDLE.
- Grant rule:
  - LSU wins if valid, except when both are valid and lsu_streak == STARVE_LIMIT; then IFU wins.
  - lsu_streak increments (saturating at STARVE_LIMIT) on each LSU grant made while ifu_req_valid=1.
  - lsu_streak clears on an IFU grant, or on an LSU grant while ifu_req_valid=0.
- ISSUE:
  - mem_req_valid=1 with latched fields, stable until mem_req_ready.
  - On mem_req_ready go to WAIT with tcnt=0.
  - ISSUE has no timeout.
- WAIT:
  - If mem_resp_valid: capture mem_resp_data (write owner: capture 0), err=0, go to RESP.
  - Else if tcnt == TIMEOUT-1: data=0, err=1, go to RESP.
  - Else tcnt+1.
  - WAIT therefore lasts at most TIMEOUT cycles; a response arriving in that last cycle wins over the timeout.
- RESP:
  - The owner's resp_valid=1 for exactly one cycle with registered data/err; the other requester's resp_valid stays 0.
  - Next state is IDLE; no new grant is made in the RESP cycle.
- Ignored responses:
  - mem_resp_valid in IDLE, ISSUE or RESP is ignored.
  - Memory must not respond to a timed-out request. A stale response is not filtered and will complete the next WAIT.
- Latency: accept at cycle T; with immediate mem_req_ready and a response one cycle later, resp_valid is at T+3. The next grant is possible at T+4.
- resp_data/resp_err hold their value until the next response to that requester.

Test Plan:
- IFU read 0x80000000, mem_req_ready=1, resp 1 cycle later with 0x0010007300000413 -> ifu_resp_valid at T+3 only; data matches; err=0; lsu_resp_valid=0; mem_req_wen=0, wmask=0.
- IFU and LSU valid in the same cycle (LSU read 0x80000100) -> LSU granted first, ifu_req_ready=0; IFU granted in the IDLE cycle after LSU RESP.
- Both held valid continuously, STARVE_LIMIT=4 -> grant order L,L,L,L,I,L,L,L,L,I.
- LSU write 0x80001000, wdata 0x1122334455667788, wmask 0x0F, mem_req_ready delayed 3 cycles -> mem_req_valid high 4 cycles with stable fields; both req_ready=0; lsu_resp_valid with data=0, err=0.
- TIMEOUT=8, memory never responds to an LSU read -> exactly 8 WAIT cycles, then lsu_resp_valid=1, err=1, data=0; a following IFU read completes normally with err=0.
- rst_n pulsed low during WAIT -> mem_req_valid, busy and all resp outputs 0 immediately; no response after release; a new IFU request completes at T+3.
